// File: rtl/pipe_stage_hs.sv
// pipe_stage_hs: valid/ready pipeline stage register with flush, saturating stall counter
// and an optional 2-entry skid buffer that keeps in_ready off the out_ready path.
module pipe_stage_hs #(
    parameter int CTRL_W = 16,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [31:0]       in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [31:0]       out_pc,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
    state_t            state;
    logic              rdy_q;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic [31:0]       skid_pc;
    logic              in_fire;
    logic              out_fire;
    assign in_ready = (SKID != 0) ? rdy_q : (!out_valid || out_ready);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    // out_ctrl is cleared in the register itself whenever the slot empties, so a bubble
    // never carries RegWrite/MemWrite downstream.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= EMPTY;
            rdy_q     <= 1'b1;
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
            out_pc    <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
            skid_pc   <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush) begin
                state     <= EMPTY;
                rdy_q     <= 1'b1;
                out_valid <= 1'b0;
                out_ctrl  <= '0;
            end else begin
                case (state)
                    EMPTY: if (in_fire) begin
                        state     <= BUSY;
                        out_valid <= 1'b1;
                        out_ctrl  <= in_ctrl;
                        out_data  <= in_data;
                        out_pc    <= in_pc;
                    end
                    BUSY: if (in_fire && out_fire) begin
                        out_ctrl <= in_ctrl;
                        out_data <= in_data;
                        out_pc   <= in_pc;
                    end else if (in_fire) begin
                        state     <= FULL;
                        rdy_q     <= 1'b0;
                        skid_ctrl <= in_ctrl;
                        skid_data <= in_data;
                        skid_pc   <= in_pc;
                    end else if (out_fire) begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        out_ctrl  <= '0;
                    end
                    FULL: if (out_fire) begin
                        state    <= BUSY;
                        rdy_q    <= 1'b1;
                        out_ctrl <= skid_ctrl;
                        out_data <= skid_data;
                        out_pc   <= skid_pc;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule
